// File: rtl/core85_min.sv
// core85_min: minimal 8085-compatible CPU core.
//
// Runs a reduced 8085 instruction subset from address 0000 until HLT, using
// the standard multiplexed bus. An opcode fetch takes 4 clocks and each
// memory read or write takes 3.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   ready, hold, sid, intr, trap, rst75, rst65, rst55
//                     present for pin compatibility only; ignored
//   addrdata  (io)    A7..A0 while ale=1, then D7..D0
//   addr      (out)   A15..A8
//   clk_out, rst_out  clk passed through; rst delayed by one clock
//   iom_, inta_, hlda, sod  constant pins
//   s1, s0            bus status: fetch 11, read 10, write 01, halt 00
//   ale, rd_, wr_     address latch enable and active-low strobes
module core85_min #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic       hold,
  input  logic       sid,
  input  logic       intr,
  input  logic       trap,
  input  logic       rst75,
  input  logic       rst65,
  input  logic       rst55,
  inout  wire  [7:0] addrdata,
  output logic [7:0] addr,
  output logic       clk_out,
  output logic       rst_out,
  output logic       iom_,
  output logic       s1,
  output logic       s0,
  output logic       inta_,
  output logic       wr_,
  output logic       rd_,
  output logic       ale,
  output logic       hlda,
  output logic       sod
);

  typedef enum logic [3:0] {
    S_F1, S_F2, S_F3, S_F4,   // opcode fetch
    S_R1, S_R2, S_R3,         // memory read
    S_W1, S_W2, S_W3,         // memory write
    S_HALT
  } state_t;

  localparam logic [2:0] R_H = 3'd4, R_L = 3'd5, R_M = 3'd6, R_A = 3'd7;

  state_t                state_q, state_d;
  logic [DATASIZE-1:0]   rf_q [8];      // B C D E H L - A; slot 6 encodes M and is never written
  logic [DATASIZE-1:0]   rf_d [8];
  logic [DATASIZE-1:0]   f_q, f_d, ir_q, ir_d, tmp_q, tmp_d;
  logic [ADDRSIZE-1:0]   pc_q, pc_d, wz_q, wz_d;
  logic [1:0]            step_q, step_d;  // operand machine cycle within the instruction
  logic                  rst_out_q, rst_out_d;

  logic [2:0]            dst, src;
  logic                  is_hlt, is_mov, is_mvi, is_inr, is_dcr, is_alu, is_alui;
  logic                  is_jmp, is_lda, is_sta;
  logic [ADDRSIZE-1:0]   hl, bus_addr;
  logic [DATASIZE-1:0]   din, alu_b, ind_res, ad_out;
  logic [15:0]           alu_out;
  logic                  ind_ac, ad_oe, halted;
  logic                  unused_pins;

  function automatic logic [7:0] flags_of(input logic [7:0] res, input logic ac, input logic cy);
    return {res[7], (res == 8'h00), 1'b0, ac, 1'b0, ~^res, 1'b1, cy};
  endfunction

  // Returns {flags, result}.
  function automatic logic [15:0] alu_op(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    logic [8:0] sum;
    logic [4:0] half;
    logic       c, ac, cy;
    logic [7:0] res;
    sum = '0; half = '0; c = 1'b0; ac = 1'b0; cy = 1'b0; res = '0;
    case (op)
      3'd0, 3'd1: begin
        c    = op[0] & cin;
        sum  = {1'b0, a} + {1'b0, b} + {8'h00, c};
        half = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, c};
        res  = sum[7:0]; ac = half[4]; cy = sum[8];
      end
      3'd2, 3'd3, 3'd7: begin
        // a + ~b + ~borrow: the inverted carry-out is the borrow, and the
        // low-nibble carry is the AC value an 8085 reports for subtraction.
        c    = ~((op == 3'd3) & cin);
        sum  = {1'b0, a} + {1'b0, ~b} + {8'h00, c};
        half = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + {4'h0, c};
        res  = sum[7:0]; ac = half[4]; cy = ~sum[8];
      end
      3'd4: begin res = a & b; ac = 1'b1; end
      3'd5: res = a ^ b;
      default: res = a | b;
    endcase
    return {flags_of(res, ac, cy), res};
  endfunction

  assign unused_pins = ^{ready, hold, sid, intr, trap, rst75, rst65, rst55};

  assign din     = addrdata;
  assign dst     = ir_q[5:3];
  assign src     = ir_q[2:0];
  assign hl      = {rf_q[R_H], rf_q[R_L]};
  assign is_hlt  = (ir_q == 8'h76);
  assign is_mov  = (ir_q[7:6] == 2'b01) && !is_hlt;
  assign is_mvi  = (ir_q[7:6] == 2'b00) && (src == 3'b110);
  assign is_inr  = (ir_q[7:6] == 2'b00) && (src == 3'b100) && (dst != R_M);
  assign is_dcr  = (ir_q[7:6] == 2'b00) && (src == 3'b101) && (dst != R_M);
  assign is_alu  = (ir_q[7:6] == 2'b10);
  assign is_alui = (ir_q[7:6] == 2'b11) && (src == 3'b110);
  assign is_jmp  = (ir_q == 8'hC3);
  assign is_lda  = (ir_q == 8'h3A);
  assign is_sta  = (ir_q == 8'h32);
  assign halted  = (state_q == S_HALT);

  assign alu_b   = (state_q == S_R3) ? din : rf_q[src];
  assign alu_out = alu_op(dst, rf_q[R_A], alu_b, f_q[0]);
  assign ind_res = is_dcr ? rf_q[dst] - 8'd1 : rf_q[dst] + 8'd1;
  assign ind_ac  = is_dcr ? (rf_q[dst][3:0] != 4'h0) : (rf_q[dst][3:0] == 4'hF);

  always_comb begin
    bus_addr = pc_q;
    if (state_q inside {S_R1, S_R2, S_R3}) begin
      if ((is_mov || is_alu) && src == R_M) bus_addr = hl;
      else if (is_lda && step_q == 2'd2)    bus_addr = wz_q;
    end else if (state_q inside {S_W1, S_W2, S_W3}) begin
      bus_addr = is_sta ? wz_q : hl;
    end
  end

  always_comb begin
    state_d = state_q; rf_d = rf_q; f_d = f_q; pc_d = pc_q; wz_d = wz_q;
    ir_d = ir_q; tmp_d = tmp_q; step_d = step_q; rst_out_d = rst;
    case (state_q)
      S_F1: state_d = S_F2;
      S_F2: state_d = S_F3;
      S_F3: begin
        ir_d    = din;
        pc_d    = pc_q + 16'd1;
        state_d = S_F4;
      end
      S_F4: begin
        step_d  = 2'd0;
        state_d = S_F1;
        if (is_hlt) begin
          state_d = S_HALT;
        end else if (is_mov) begin
          if (dst == R_M) begin tmp_d = rf_q[src]; state_d = S_W1; end
          else if (src == R_M) state_d = S_R1;
          else rf_d[dst] = rf_q[src];
        end else if (is_mvi || is_alui || is_jmp || is_lda || is_sta) begin
          tmp_d   = rf_q[R_A];
          state_d = S_R1;
        end else if (is_inr || is_dcr) begin
          rf_d[dst] = ind_res;
          f_d       = flags_of(ind_res, ind_ac, f_q[0]);
        end else if (is_alu) begin
          if (src == R_M) state_d = S_R1;
          else begin
            f_d = alu_out[15:8];
            if (dst != 3'd7) rf_d[R_A] = alu_out[7:0];
          end
        end
      end
      S_R1: state_d = S_R2;
      S_R2: state_d = S_R3;
      S_R3: begin
        state_d = S_F1;
        step_d  = step_q + 2'd1;
        if (is_mvi) begin
          pc_d = pc_q + 16'd1;
          if (dst == R_M) begin tmp_d = din; state_d = S_W1; end
          else rf_d[dst] = din;
        end else if (is_mov) begin
          rf_d[dst] = din;
        end else if (is_alu || is_alui) begin
          if (is_alui) pc_d = pc_q + 16'd1;
          f_d = alu_out[15:8];
          if (dst != 3'd7) rf_d[R_A] = alu_out[7:0];
        end else if (step_q == 2'd0) begin
          wz_d[7:0] = din;
          pc_d      = pc_q + 16'd1;
          state_d   = S_R1;
        end else if (step_q == 2'd1) begin
          wz_d[15:8] = din;
          pc_d       = is_jmp ? {din, wz_q[7:0]} : pc_q + 16'd1;
          if (is_lda) state_d = S_R1;
          if (is_sta) state_d = S_W1;
        end else begin
          rf_d[R_A] = din;
        end
      end
      S_W1: state_d = S_W2;
      S_W2: state_d = S_W3;
      S_W3: state_d = S_F1;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_out_q <= rst_out_d;
    if (rst) begin
      state_q <= S_F1;
      rf_q    <= '{default: '0};
      f_q     <= '0;
      ir_q    <= '0;
      tmp_q   <= '0;
      pc_q    <= '0;
      wz_q    <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      f_q     <= f_d;
      ir_q    <= ir_d;
      tmp_q   <= tmp_d;
      pc_q    <= pc_d;
      wz_q    <= wz_d;
      step_q  <= step_d;
    end
  end

  // Bus pins. rst is also used combinationally so that the pins sit idle
  // during the reset clocks even though the state register shows T1.
  always_comb begin
    ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1; {s1, s0} = 2'b11;
    ad_oe = 1'b0; ad_out = bus_addr[7:0];
    if (!rst) begin
      case (state_q)
        S_F1:       begin ale = 1'b1; ad_oe = 1'b1; end
        S_F2, S_F3: rd_ = 1'b0;
        S_R1:       begin ale = 1'b1; ad_oe = 1'b1; {s1, s0} = 2'b10; end
        S_R2, S_R3: begin rd_ = 1'b0; {s1, s0} = 2'b10; end
        S_W1:       begin ale = 1'b1; ad_oe = 1'b1; {s1, s0} = 2'b01; end
        S_W2, S_W3: begin wr_ = 1'b0; ad_oe = 1'b1; ad_out = tmp_q; {s1, s0} = 2'b01; end
        S_HALT:     {s1, s0} = 2'b00;
        default:    ;
      endcase
    end
  end

  assign addrdata = ad_oe ? ad_out : {DATASIZE{1'bz}};
  assign addr     = bus_addr[15:8];
  assign clk_out  = clk;
  assign rst_out  = rst_out_q;
  assign iom_     = 1'b0;
  assign inta_    = 1'b1;
  assign hlda     = 1'b0;
  assign sod      = 1'b0;

endmodule

// File: tb/tb_core85_min.sv
// Bench for core85_min: a 64 KB memory model answers the bus, and a
// scoreboard of expected bus cycles is compared against each cycle the core
// starts. Register, flag and memory contents are checked once the core halts.
module tb_core85_min;

  logic       clk, rst;
  logic       ready, hold, sid, intr, trap, rst75, rst65, rst55;
  wire  [7:0] addrdata;
  logic [7:0] addr;
  logic       clk_out, rst_out, iom_, s1, s0, inta_, wr_, rd_, ale, hlda, sod;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_t;

  logic [7:0]  mem [0:65535];
  logic [15:0] lat_addr;
  logic [1:0]  lat_kind;
  int          ph;
  int          n_chk, n_fail;
  bus_t        sb_q [$];

  core85_min dut (
    .clk(clk), .rst(rst), .ready(ready), .hold(hold), .sid(sid),
    .intr(intr), .trap(trap), .rst75(rst75), .rst65(rst65), .rst55(rst55),
    .addrdata(addrdata), .addr(addr), .clk_out(clk_out), .rst_out(rst_out),
    .iom_(iom_), .s1(s1), .s0(s0), .inta_(inta_), .wr_(wr_), .rd_(rd_),
    .ale(ale), .hlda(hlda), .sod(sod)
  );

  assign addrdata = (rd_ == 1'b0) ? mem[lat_addr] : 8'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ef(input logic [15:0] a);
    sb_q.push_back({2'b11, a, 8'h00});
  endtask
  task automatic er(input logic [15:0] a);
    sb_q.push_back({2'b10, a, 8'h00});
  endtask
  task automatic ew(input logic [15:0] a, input logic [7:0] d);
    sb_q.push_back({2'b01, a, d});
  endtask

  // bytes is right-aligned: the first program byte is the most significant of n.
  task automatic load(input logic [127:0] bytes, input int n);
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < n; i++) mem[16'(i)] = bytes[8*(n-1-i) +: 8];
    sb_q.delete();
  endtask

  // Bus monitor: captures the address at T1 and pops the scoreboard at T2.
  initial begin
    bus_t e;
    ph = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 0;
      end else if (ale) begin
        lat_addr = {addr, addrdata};
        lat_kind = {s1, s0};
        ph = 1;
      end else if (ph == 1) begin
        ph = 2;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(lat_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("bus_kind", 32'(lat_kind), 32'(e.kind));
          chk("bus_addr", 32'(lat_addr), 32'(e.addr));
          if (lat_kind == 2'b01) begin
            chk("wr_data", 32'(addrdata), 32'(e.data));
            mem[lat_addr] = addrdata;
          end
        end
        if (lat_kind == 2'b01) chk("wr_t2", 32'(wr_), 0);
        else                   chk("rd_t2", 32'(rd_), 0);
      end else if (ph == 2) begin
        ph = 0;
        if (lat_kind == 2'b01) chk("wr_t3", 32'(wr_), 0);
        else                   chk("rd_t3", 32'(rd_), 0);
      end
    end
  end

  // Holds rst for three rising edges and releases it just after the third.
  task automatic reset_dut();
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("rst_ale", 32'(ale), 0);
        chk("rst_rd", 32'(rd_), 1);
        chk("rst_wr", 32'(wr_), 1);
        chk("rst_s1s0", 32'({s1, s0}), 3);
        chk("rst_oe", 32'(dut.ad_oe), 0);
        chk("rst_out_hi", 32'(rst_out), 1);
        chk("rst_pc", 32'(dut.pc_q), 0);
        chk("pins", 32'({iom_, inta_, hlda, sod, clk_out}), 32'b01000);
      end
      @(posedge clk);
    end
    #1; rst = 1'b0;
  endtask

  task automatic run_prog(input int exp_halt);
    int   n;
    logic seen;
    reset_dut();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      case (n)
        0: begin
          chk("t1_ale", 32'(ale), 1);
          chk("t1_addr", 32'(addr), 0);
          chk("t1_ad", 32'(addrdata), 0);
          chk("t1_rst_out", 32'(rst_out), 1);
        end
        1: begin
          chk("t2_ale", 32'(ale), 0);
          chk("t2_rd", 32'(rd_), 0);
          chk("t2_rst_out", 32'(rst_out), 0);
        end
        2: chk("t3_rd", 32'(rd_), 0);
        3: chk("t4_rd", 32'(rd_), 1);
        default: ;
      endcase
      if (dut.halted) seen = 1'b1;
      else n++;
    end
    chk("halt_seen", 32'(seen), 1);
    chk("halt_cycle", 32'(n), 32'(exp_halt));
    chk("halt_s1s0", 32'({s1, s0}), 0);
    chk("halt_pins", 32'({ale, rd_, wr_, dut.ad_oe}), 32'b0110);
    chk("sb_drain", 32'(sb_q.size()), 0);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; hold = 1'b0; sid = 1'b0;
    intr = 1'b0; trap = 1'b0; rst75 = 1'b0; rst65 = 1'b0; rst55 = 1'b0;
    n_chk = 0; n_fail = 0;

    // Reset in the middle of a fetch abandons it and clears the registers.
    load(128'h3E5506AA8076, 6);
    ef(16'h0000); er(16'h0001); ef(16'h0002);
    reset_dut();
    repeat (9) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("abort_ale", 32'(ale), 0);
    chk("abort_rd", 32'(rd_), 1);
    @(negedge clk);
    chk("abort_pc", 32'(dut.pc_q), 0);
    chk("abort_a", 32'(dut.rf_q[7]), 0);
    chk("abort_s1s0", 32'({s1, s0}), 3);
    chk("abort_sb", 32'(sb_q.size()), 0);

    // MVI A,55; MVI B,AA; ADD B; HLT
    load(128'h3E5506AA8076, 6);
    ef(16'h0000); er(16'h0001); ef(16'h0002); er(16'h0003); ef(16'h0004); ef(16'h0005);
    run_prog(22);
    chk("p1_a", 32'(dut.rf_q[7]), 32'hFF);
    chk("p1_b", 32'(dut.rf_q[0]), 32'hAA);
    chk("p1_f", 32'(dut.f_q & 8'hFD), 32'h84);
    chk("p1_f1", 32'(dut.f_q[1]), 1);
    chk("p1_pc", 32'(dut.pc_q), 32'h0006);

    // MVI A,0F; SUI 10; HLT
    load(128'h3E0FD61076, 5);
    ef(16'h0000); er(16'h0001); ef(16'h0002); er(16'h0003); ef(16'h0004);
    run_prog(18);
    chk("p2_a", 32'(dut.rf_q[7]), 32'hFF);
    chk("p2_f", 32'(dut.f_q & 8'hFD), 32'h95);

    // MVI H,80; MVI L,00; MVI M,5A; LDA 8000; HLT
    load(128'h2680_2E00_365A_3A0080_76, 10);
    ef(16'h0000); er(16'h0001); ef(16'h0002); er(16'h0003);
    ef(16'h0004); er(16'h0005); ew(16'h8000, 8'h5A);
    ef(16'h0006); er(16'h0007); er(16'h0008); er(16'h8000);
    ef(16'h0009);
    run_prog(41);
    chk("p3_a", 32'(dut.rf_q[7]), 32'h5A);
    chk("p3_hl", 32'({dut.rf_q[4], dut.rf_q[5]}), 32'h8000);
    chk("p3_mem", 32'(mem[16'h8000]), 32'h5A);

    // JMP 0010; HLT at 0010
    load(128'hC31000, 3);
    mem[16'h0010] = 8'h76;
    ef(16'h0000); er(16'h0001); er(16'h0002); ef(16'h0010);
    run_prog(14);
    chk("p4_pc", 32'(dut.pc_q), 32'h0011);

    // MVI A,33; undefined 08 runs as NOP; HLT
    load(128'h3E330876, 4);
    ef(16'h0000); er(16'h0001); ef(16'h0002); ef(16'h0003);
    run_prog(15);
    chk("p5_a", 32'(dut.rf_q[7]), 32'h33);
    chk("p5_b", 32'(dut.rf_q[0]), 0);
    chk("p5_f", 32'(dut.f_q), 0);
    chk("p5_pc", 32'(dut.pc_q), 32'h0004);

    // MVI A,7F; INR A; MOV B,A; STA 9000; CPI 80; ANI 0F; HLT
    load(128'h3E7F_3C_47_320090_FE80_E60F_76, 12);
    ef(16'h0000); er(16'h0001); ef(16'h0002); ef(16'h0003);
    ef(16'h0004); er(16'h0005); er(16'h0006); ew(16'h9000, 8'h80);
    ef(16'h0007); er(16'h0008); ef(16'h0009); er(16'h000A); ef(16'h000B);
    run_prog(46);
    chk("p6_a", 32'(dut.rf_q[7]), 0);
    chk("p6_b", 32'(dut.rf_q[0]), 32'h80);
    chk("p6_f", 32'(dut.f_q & 8'hFD), 32'h54);
    chk("p6_f1", 32'(dut.f_q[1]), 1);
    chk("p6_mem", 32'(mem[16'h9000]), 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core85_min.md
Name: core85_min

Overview:
- Minimal 8085-compatible CPU core with a multiplexed 8085-style external bus (AD7..AD0 plus A15..A8) and standard control/status pins.
- It executes a reduced instruction subset, from reset until HLT.
- It is the CPU block of the small-system test platform.
- Interrupt, DMA/hold, wait-state and serial pins are present for pin compatibility but are inactive.

Parameters:
- DATASIZE, 8, data bus / register width (fixed).
- ADDRSIZE, 16, address width (fixed).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ready  in  1  wait request; ignored (no wait states).
- hold  in  1  DMA hold request; ignored.
- sid  in  1  serial input; ignored.
- intr, trap, rst75, rst65, rst55  in  1 each  interrupt requests; ignored.
- addrdata  inout  8  multiplexed A7..A0 / D7..D0.
- addr  out  8  A15..A8.
- clk_out  out  1  equals clk.
- rst_out  out  1  rst registered by one clock.
- iom_  out  1  always 0 (memory space).
- s1, s0  out  1 each  bus status: fetch 11, read 10, write 01, halt 00.
- inta_  out  1  constant 1.
- wr_  out  1  write strobe, active-low.
- rd_  out  1  read strobe, active-low.
- ale  out  1  address latch enable.
- hlda  out  1  constant 0.
- sod  out  1  constant 0.

Behaviour:
- Internal state: B,C,D,E,H,L,F,A (8-bit); PC, SP, temp-pointer (16-bit); IR; temp (8-bit).
- Reset: all registers 0, PC=0000, IR=00, state=T1 of opcode fetch; ale=0, rd_=wr_=1, addrdata high-Z, s1s0=11.
- Opcode fetch (M1), 4 clocks:
  - T1: ale=1, addr=PC[15:8], addrdata=PC[7:0].
  - T2: ale=0, rd_=0, addrdata high-Z.
  - T3: rd_=0; IR loads addrdata at end of T3; PC+1.
  - T4: decode; register-only operations complete at end of T4.
- Memory read, 3 clocks: T1/T2/T3 as above; s1s0=10; data latched at end of T3.
- Memory write, 3 clocks:
  - T1 carries the address (ale=1).
  - T2–T3: wr_=0 and addrdata drives data; s1s0=01.
- Instruction subset; any other opcode executes as NOP (4 clocks):
  - NOP 00.
  - MOV r,r' 40–7F except 76; r=110 means memory at HL.
  - MVI r,d8 06/0E/16/1E/26/2E/36/3E.
  - ALU r: 80–BF (ADD, ADC, SUB, SBB, ANA, XRA, ORA, CMP).
  - ALU immediate: C6/CE/D6/DE/E6/EE/F6/FE.
  - INR r / DCR r (04/05 family).
  - JMP a16 C3.
  - LDA a16 3A; STA a16 32.
  - HLT 76.
- Register encoding: 000 B, 001 C, 010 D, 011 E, 100 H, 101 L, 110 M, 111 A.
- Cycle counts:
  - 4: MOV r,r; ALU r; INR/DCR r.
  - 7: MVI r; ALU imm; MOV r,M; MOV M,r; ALU M.
  - 10: JMP; MVI M.
  - 13: LDA, STA.
  - 5: HLT (4 clocks, then halt state).
- Flags F = {S,Z,0,AC,0,P,1,CY}; F resets to 00 and bit1 reads 1 after the first flag write.
- ALU ops update all flags. ANA sets AC=1, CY=0; XRA/ORA clear AC and CY.
- SUB/SBB/CMP: CY = borrow. CMP leaves A unchanged.
- INR/DCR update S, Z, AC, P; CY unchanged.
- Arithmetic wraps modulo 256; PC wraps FFFF→0000.
- JMP: PC ← fetched 16-bit address, low byte first.
- HLT:
  - After T4 of the HLT fetch, enter halt state: s1s0=00, ale=0, rd_=wr_=1, addrdata high-Z.
  - Remains in halt until rst; a halt-state flag is exposed internally for benches.
- rst asserted at any clock edge, including mid-cycle, aborts the current bus cycle and applies reset values at that edge.

Test Plan:
- Reset held 3 clocks, then released → first T1 at PC=0000; ale=1 for one clock; addr=00, addrdata=00; rd_ low in T2–T3.
- 3E 55 06 AA 80 76 (MVI A; MVI B; ADD B; HLT) → A=FF, B=AA, F=84 (S=1, P=1, others 0); halt reached after 7+7+4+5 clocks; s1s0=00.
- 3E 0F D6 10 76 → A=FF, CY=1, S=1, AC=1; F=95 per layout.
- 21-style setup via MVI H,80; MVI L,00; then 36 5A (MVI M) and 3A 00 80 (LDA) → write cycle at 8000 with wr_ low in T2–T3 and data 5A; A=5A.
- C3 10 00 with HLT at 0010 → next fetch address 0010; halt.
- Undefined opcode 08, then 76 → 4-clock NOP, registers unchanged, then halt.
